ls_sequencer: RTL
=================

# ls_sequencer

Multicycle load/store/immediate sequencer that sits directly upstream of the 32×64-bit register bank. It accepts one decoded instruction at a time over a valid/ready handshake and drives the bank read addresses (Ra, Rb). It computes effective addresses from doutA, performs the data-memory transaction over a req/ack handshake, and drives the bank write port (Rw, WE_Reg, dIN) for loads and ADDI.

## Interface
- DATA_W, 64, datapath and memory data/address width
- IMM_W, 12, signed immediate width
- MEM_TIMEOUT, 16, max cycles waiting for mem_ack before abort (≥1)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- instr_valid  in  1  instruction present
- instr_ready  out  1  sequencer can accept
- instr_op  in  2  00 NOP, 01 LOAD (rd ← mem[rs1+imm]), 10 STORE (mem[rs1+imm] ← rs2), 11 ADDI (rd ← rs1+imm)
- instr_rs1, instr_rs2, instr_rd  in  5 each  register indices
- instr_imm  in  IMM_W  signed immediate
- Ra, Rb  out  5  bank read addresses (rs1, rs2)
- doutA, doutB  in  DATA_W  bank read data, combinational from Ra/Rb
- Rw  out  5  bank write address
- WE_Reg  out  1  bank write enable
- dIN  out  DATA_W  bank write data
- mem_req  out  1  memory request
- mem_we  out  1  1 = store, 0 = load
- mem_addr, mem_wdata  out  DATA_W  address, store data
- mem_ack  in  1  memory completion
- mem_rdata  in  DATA_W  load data, valid with mem_ack
- busy  out  1  high in any state except IDLE
- err  out  1  sticky memory-timeout flag

## Operation
- FSM states: IDLE, READ, MEM, WB.
- IDLE: instr_ready=1. On instr_valid&&instr_ready, latch op/rs1/rs2/rd/imm. Ra←rs1, Rb←rs2. NOP stays in IDLE; other ops go to READ.
- READ (1 cycle): sample doutA/doutB. sum = doutA + sign_extend(imm), modulo 2^DATA_W (wrap, no flag). LOAD/STORE: mem_addr←sum, mem_wdata←doutB, mem_we←(op==STORE) → MEM. ADDI: dIN←sum → WB.
- MEM: mem_req=1, held with address/data/we stable until mem_ack is sampled high. Wait counter increments each MEM cycle.
  - On ack: LOAD latches dIN←mem_rdata → WB; STORE → IDLE.
  - If the counter reaches MEM_TIMEOUT without ack: drop mem_req, set err=1, no writeback → IDLE.
- WB (1 cycle): Rw=rd, WE_Reg=1 unless rd==0 (x0 writes suppressed, WE_Reg stays 0) → IDLE.
- mem_ack outside MEM is ignored.
- err is cleared only by reset.
- Ra/Rb hold their last value until the next accept.

## Timing
- Reset (rst_n low at an edge): state IDLE. Outputs after the edge: instr_ready=1 once rst_n high (0 while held low), busy=0, err=0, mem_req=0, mem_we=0, WE_Reg=0, Ra=Rb=Rw=0, dIN=mem_addr=mem_wdata=0, wait counter 0.
- Reset mid-operation: transaction abandoned at that edge. mem_req and WE_Reg are 0 the following cycle, with no writeback.
- Accept at edge T: busy=1 from T (post-edge).
  - ADDI: WE_Reg high cycle T+2.
  - LOAD, ack in the first MEM cycle: mem_req high T+2, WE_Reg high T+3.
  - STORE, ack in the first MEM cycle: mem_req high T+2.
  - Each extra ack-wait cycle adds 1.
  - instr_ready returns 1 the cycle after WB (or after MEM for STORE or timeout).
- mem_ack may arrive in the same cycle mem_req first rises; it is sampled at that edge.
- Timeout: mem_req is high for exactly MEM_TIMEOUT cycles. err rises the cycle after the last one.
- WE_Reg is a single-cycle pulse; Rw/dIN are stable during it.
- At most one transaction is in flight; instr_valid while busy is not accepted.

## Test plan
- Reset then ADDI rs1=1 (doutA=5), imm=7, rd=7 → WE_Reg pulse at T+2, Rw=7, dIN=12; instr_ready high at T+3.
- LOAD rs1=2 (doutA=0x100), imm=-8, rd=3; memory acks after 2 wait cycles with rdata=0xDEAD → mem_addr=0xF8, mem_we=0, req high 3 cycles, then WE_Reg with Rw=3, dIN=0xDEAD.
- STORE rs1=1 (doutA=0xFFFF_FFFF_FFFF_FFFC), rs2=4 (doutB=42), imm=8, immediate ack → mem_addr=0x4 (wrap), mem_wdata=42, mem_we=1, no WE_Reg, ready at T+3.
- LOAD with mem_ack never asserted, MEM_TIMEOUT=16 → mem_req high 16 cycles, then err=1, no WE_Reg, IDLE; err stays 1 across further ADDIs until rst_n low.
- ADDI rd=0, and NOP → WE_Reg never asserted; NOP leaves busy=0 and ready=1 continuously.
- rst_n low during MEM of a LOAD with ack arriving the same cycle → no WE_Reg, mem_req=0 next cycle, all outputs at reset values.

Source files
------------

// File: rtl/ls_sequencer.sv
// ls_sequencer: multicycle LOAD/STORE/ADDI sequencer driving a 32x64 register bank
// and a req/ack data-memory port.
module ls_sequencer #(
  parameter int DATA_W      = 64,
  parameter int IMM_W       = 12,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [1:0]        instr_op,
  input  logic [4:0]        instr_rs1,
  input  logic [4:0]        instr_rs2,
  input  logic [4:0]        instr_rd,
  input  logic [IMM_W-1:0]  instr_imm,
  output logic [4:0]        Ra,
  output logic [4:0]        Rb,
  input  logic [DATA_W-1:0] doutA,
  input  logic [DATA_W-1:0] doutB,
  output logic [4:0]        Rw,
  output logic              WE_Reg,
  output logic [DATA_W-1:0] dIN,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              err
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_ADDI  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_MEM,
    S_WB
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [1:0]          r_op;
  logic [IMM_W-1:0]    r_imm;
  logic [4:0]          r_ra;
  logic [4:0]          r_rb;
  logic [4:0]          r_rw;
  logic [DATA_W-1:0]   r_din;
  logic [DATA_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_we;
  logic                r_err;
  logic [CW-1:0]       r_cnt;
  logic                w_accept;
  logic                w_timeout;
  logic [DATA_W-1:0]   w_sum;

  assign w_accept  = (r_state == S_IDLE) && instr_valid;
  assign w_timeout = (r_cnt == CW'(MEM_TIMEOUT - 1));
  assign w_sum     = doutA
                   + {{(DATA_W-IMM_W){r_imm[IMM_W-1]}}, r_imm};

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && (instr_op != OP_NOP)) w_next = S_READ;
      end
      S_READ: begin
        w_next = (r_op == OP_ADDI) ? S_WB : S_MEM;
      end
      S_MEM: begin
        if (mem_ack)
          w_next = (r_op == OP_LOAD) ? S_WB : S_IDLE;
        else if (w_timeout)
          w_next = S_IDLE;
      end
      S_WB:    w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_op    <= OP_NOP;
      r_imm   <= '0;
      r_ra    <= '0;
      r_rb    <= '0;
      r_rw    <= '0;
      r_din   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op  <= instr_op;
        r_imm <= instr_imm;
        r_ra  <= instr_rs1;
        r_rb  <= instr_rs2;
        r_rw  <= instr_rd;
      end
      if (r_state == S_READ) begin
        r_cnt <= '0;
        if (r_op == OP_ADDI) begin
          r_din <= w_sum;
        end else begin
          r_addr  <= w_sum;
          r_wdata <= doutB;
          r_we    <= (r_op == OP_STORE);
        end
      end
      // Counter runs every MEM cycle; the last unacked one trips err.
      if (r_state == S_MEM) begin
        r_cnt <= r_cnt + CW'(1);
        if (mem_ack && (r_op == OP_LOAD)) r_din <= mem_rdata;
        if (!mem_ack && w_timeout) r_err <= 1'b1;
      end
    end
  end

  assign instr_ready = rst_n && (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign mem_req     = (r_state == S_MEM);
  assign WE_Reg      = (r_state == S_WB) && (r_rw != 5'd0);
  assign Ra          = r_ra;
  assign Rb          = r_rb;
  assign Rw          = r_rw;
  assign dIN         = r_din;
  assign mem_addr    = r_addr;
  assign mem_wdata   = r_wdata;
  assign mem_we      = r_we;
  assign err         = r_err;

endmodule
